// File: rtl/if_id_fifo.sv
// if_id_fifo: DEPTH-entry fetch/decode buffer with valid/ready on both sides and single-cycle flush.
// Define IF_ID_PERF_EN to add the stall_cycles and flush_count performance counters.
module if_id_fifo #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
`ifdef IF_ID_PERF_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count,
`endif
  output logic [CNT_W-1:0]  count
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] mem_pc [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic full, empty, push, pop;
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign if_ready = !full;
  assign id_valid = !empty;
  assign push = if_valid && if_ready && !flush;
  assign pop = id_valid && id_ready && !flush;
  // head is forced to zero when empty so decode sees a NOP bubble
  assign id_pc = empty ? '0 : mem_pc[rd_ptr];
  assign id_inst = empty ? '0 : mem_inst[rd_ptr];
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr] <= if_pc;
      mem_inst[wr_ptr] <= if_inst;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
`ifdef IF_ID_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      if (if_valid && !if_ready) stall_cycles <= stall_cycles + 1'b1;
      if (flush) flush_count <= flush_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_if_id_fifo.sv
// tb_if_id_fifo: randomized and directed scoreboard bench for if_id_fifo against a queue model.
module tb_if_id_fifo;
  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic clk = 0, rst = 1, flush = 0, if_valid = 0, id_ready = 0;
  logic [31:0] if_pc = 0, if_inst = 0;
  logic if_ready, id_valid;
  logic [31:0] id_pc, id_inst;
  logic [CNT_W-1:0] count;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cycles, flush_count;
  int exp_stalls = 0, exp_flushes = 0;
`endif
  int n_chk = 0, n_fail = 0;
  logic took = 0;
  logic [63:0] q[$];

  if_id_fifo #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst),
`ifdef IF_ID_PERF_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " if_ready"}, 64'(if_ready), 64'd1);
    chk({tag, " id_valid"}, 64'(id_valid), 64'd0);
    chk({tag, " id_pc"}, 64'(id_pc), 64'd0);
    chk({tag, " id_inst"}, 64'(id_inst), 64'd0);
    chk({tag, " count"}, 64'(count), 64'd0);
  endtask

  // monitor: compare DUT against the queue model mid-cycle, then advance the model
  always @(negedge clk) begin
    logic full, push, pop;
    if (rst) begin
      q.delete();
      took = 1;
      chk_reset_outputs("reset");
`ifdef IF_ID_PERF_EN
      exp_stalls = 0;
      exp_flushes = 0;
      chk("reset stall_cycles", 64'(stall_cycles), 64'd0);
      chk("reset flush_count", 64'(flush_count), 64'd0);
`endif
    end else begin
      full = q.size() == DEPTH;
      chk("if_ready", 64'(if_ready), 64'(!full));
      chk("id_valid", 64'(id_valid), 64'(q.size() != 0));
      chk("count", 64'(count), 64'(q.size()));
      if (q.size() != 0) begin
        chk("head id_pc", 64'(id_pc), 64'(q[0][63:32]));
        chk("head id_inst", 64'(id_inst), 64'(q[0][31:0]));
      end else begin
        chk("bubble id_pc", 64'(id_pc), 64'd0);
        chk("bubble id_inst", 64'(id_inst), 64'd0);
      end
`ifdef IF_ID_PERF_EN
      chk("stall_cycles", 64'(stall_cycles), 64'(exp_stalls));
      chk("flush_count", 64'(flush_count), 64'(exp_flushes));
      if (if_valid && full) exp_stalls++;
      if (flush) exp_flushes++;
`endif
      push = if_valid && !full && !flush;
      pop = q.size() != 0 && id_ready && !flush;
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back({if_pc, if_inst});
      end
      took = push || flush;
    end
  end

  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                     input logic r, input logic f);
    @(posedge clk);
    #1;
    if_valid = v;
    if_pc = pc;
    if_inst = inst;
    id_ready = r;
    flush = f;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // single push with decode stalled
    cyc(1, 32'h100, 32'h3C011234, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    // fill to full, hold third offer, then drain with pointer wrap
    cyc(1, 32'h100, 32'hA0, 0, 0);
    cyc(1, 32'h104, 32'hA1, 0, 0);
    repeat (3) cyc(1, 32'h108, 32'hA2, 0, 0);
    cyc(1, 32'h108, 32'hA2, 1, 0);
    cyc(1, 32'h108, 32'hA2, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    // continuous stream
    for (int i = 0; i < 8; i++) cyc(1, 32'h100 + 32'(4 * i), 32'hB0 + 32'(i), 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    // flush with a coincident offer and pop
    cyc(1, 32'h300, 32'hC0, 0, 0);
    cyc(1, 32'h304, 32'hC1, 0, 0);
    cyc(1, 32'h200, 32'hDEAD, 1, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    // randomized traffic, offers held until accepted or flushed
    for (int i = 0; i < 400; i++) begin
      logic v;
      logic [31:0] pc, inst;
      v = if_valid;
      pc = if_pc;
      inst = if_inst;
      if (took || !if_valid) begin
        v = $urandom_range(0, 3) != 0;
        pc = $urandom;
        inst = $urandom;
      end
      cyc(v, pc, inst, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // asynchronous reset while holding two entries
    cyc(1, 32'h400, 32'hE0, 0, 0);
    cyc(1, 32'h404, 32'hE1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("pre-reset count", 64'(count), 64'd2);
    rst = 1;
    #1;
    chk_reset_outputs("async");
    @(posedge clk);
    #1 rst = 0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
